// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder
// Destination-domain consumer for a gray-coded count. Brings the asynchronous
// gray bus into clk through a STAGES-deep synchronizer, converts it to binary
// and reports the per-cycle advance (step, delta).
// Optional multi-bit-change checker enabled by defining GRAY_SYNC_CHECK_EN;
// without it err is tied low and err_clr is ignored.
module gray_sync_decoder #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             step,
    output logic [WIDTH-1:0] delta,
    output logic             err
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_last;

    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] delta_q, delta_d;
    logic             step_q, step_d;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b            = '0;
        b[WIDTH-1]   = g[WIDTH-1];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            b[WIDTH-1-i] = b[WIDTH-i] ^ g[WIDTH-1-i];
        end
        return b;
    endfunction

    assign sync_last = sync_q[STAGES-1];

    // Plain flop chain from the asynchronous bus; no logic between stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= gray_in;
            for (int unsigned k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Next output values derived from the last synchronizer stage.
    always_comb begin
        gray_d  = sync_last;
        bin_d   = g2b(sync_last);
        step_d  = (sync_last != gray_q);
        // Equal gray implies equal binary, so delta is naturally 0 without a step.
        delta_d = bin_d - bin_q;
    end

    // Output register: gray, binary, step and delta update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gray_q  <= '0;
            bin_q   <= '0;
            step_q  <= 1'b0;
            delta_q <= '0;
        end else begin
            gray_q  <= gray_d;
            bin_q   <= bin_d;
            step_q  <= step_d;
            delta_q <= delta_d;
        end
    end

    assign gray_out = gray_q;
    assign bin_out  = bin_q;
    assign step     = step_q;
    assign delta    = delta_q;

`ifdef GRAY_SYNC_CHECK_EN
    logic err_q, err_d;
    logic viol;

    // Sticky flag for sampled transitions that flip more than one bit; a new
    // violation takes priority over a simultaneous clear.
    always_comb begin
        viol  = ($countones(sync_last ^ gray_q) > 1);
        err_d = viol | (err_q & ~err_clr);
    end

    // Sticky error register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Testbench for gray_sync_decoder: directed scenarios followed by a random
// walk, all compared against a queue-based delay-line reference model.
module tb_gray_sync_decoder;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         err_clr;
    logic [W-1:0] gray_in;
    logic [W-1:0] gray_out;
    logic [W-1:0] bin_out;
    logic         step;
    logic [W-1:0] delta;
    logic         err;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [W-1:0] pipe [$];
    logic [W-1:0] m_gray, m_bin, m_delta;
    logic         m_step, m_err;
    logic [W-1:0] cur_bin;

    always #5 clk = ~clk;

    gray_sync_decoder #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .gray_in  (gray_in),
        .err_clr  (err_clr),
        .gray_out (gray_out),
        .bin_out  (bin_out),
        .step     (step),
        .delta    (delta),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary is the XOR of all right-shifts of the gray value.
    function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int s = 0; s < W; s++) b ^= (g >> s);
        return b;
    endfunction

    function automatic int ones(input logic [W-1:0] x);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) if (x[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < S; i++) pipe.push_back('0);
        m_gray  = '0;
        m_bin   = '0;
        m_delta = '0;
        m_step  = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock edge of the model: the value sampled S edges ago emerges.
    task automatic model_edge(input logic [W-1:0] g, input logic clr);
        logic [W-1:0] ng, nb;
        ng = pipe.pop_front();
        pipe.push_back(g);
        nb      = to_bin(ng);
        m_step  = (ng != m_gray);
        m_delta = nb - m_bin;
`ifdef GRAY_SYNC_CHECK_EN
        m_err   = (ones(ng ^ m_gray) > 1) || (m_err && !clr);
`else
        m_err   = 1'b0;
`endif
        m_gray  = ng;
        m_bin   = nb;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(gray_in, err_clr);
        #1;
        check("gray_out", gray_out, m_gray);
        check("bin_out",  bin_out,  m_bin);
        check("step",     step,     m_step);
        check("delta",    delta,    m_delta);
        check("err",      err,      m_err);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gray"},  gray_out, 0);
        check({tag, "_bin"},   bin_out,  0);
        check({tag, "_step"},  step,     0);
        check({tag, "_delta"}, delta,    0);
        check({tag, "_err"},   err,      0);
    endtask

    // Asynchronous reset asserted between edges, released on a falling edge.
    task automatic do_reset(input int cycles);
        #2;
        reset = 1'b1;
        #1;
        check_zero("rst_async");
        model_reset();
        repeat (cycles) @(posedge clk);
        #1;
        check_zero("rst_hold");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        reset   = 1'b1;
        err_clr = 1'b0;
        gray_in = 4'b0110;
        model_reset();
        #3;
        check_zero("rst_init");
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_init_hold");
        @(negedge clk);
        reset = 1'b0;

        // Reset release with a non-zero bus: value appears on the 3rd edge.
        tick(); tick();
        check("rst_early_step", step, 0);
        tick();
        check("rst_bin",   bin_out, 4);
        check("rst_step",  step,    1);
        check("rst_delta", delta,   4);
        tick();
        check("rst_step_after", step, 0);

        // Latency from steady zero.
        gray_in = '0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (4) tick();
        gray_in = 4'b0001;
        tick(); tick();
        check("lat_early_bin", bin_out, 0);
        tick();
        check("lat_bin",   bin_out, 1);
        check("lat_step",  step,    1);
        check("lat_delta", delta,   1);
        tick();
        check("lat_step_next", step, 0);

        // Wrap sweep: one value every 4 clocks, 0..15 then 0.
        for (int i = 0; i <= 16; i++) begin
            logic [W-1:0] b;
            b = W'(i % 16);
            gray_in = to_gray(b);
            repeat (4) tick();
            check("wrap_bin", bin_out, b);
            check("wrap_err", err, 0);
        end

        // Multi-bit jump 0000 -> 0111 (binary 5).
        gray_in = 4'b0111;
        tick(); tick(); tick();
        check("viol_bin", bin_out, 5);
`ifdef GRAY_SYNC_CHECK_EN
        check("viol_err", err, 1);
`else
        check("viol_err", err, 0);
`endif
        gray_in = to_gray(4'd6);
        repeat (4) tick();
`ifdef GRAY_SYNC_CHECK_EN
        check("viol_sticky", err, 1);
`else
        check("viol_sticky", err, 0);
`endif
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("viol_clr", err, 0);
        tick();

        // Set err, then a second violation coincident with err_clr.
        gray_in = 4'b0000;
        repeat (4) tick();
        gray_in = 4'b0011;
        tick(); tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("simul_bin", bin_out, 2);
`ifdef GRAY_SYNC_CHECK_EN
        check("simul_err", err, 1);
`else
        check("simul_err", err, 0);
`endif
        tick();

        // Mid-run reset while holding gray 0101 (binary 6).
        gray_in = 4'b0101;
        repeat (4) tick();
        do_reset(1);
        tick(); tick(); tick();
        check("mid_bin",   bin_out, 6);
        check("mid_step",  step,    1);
        check("mid_delta", delta,   6);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Random walk: mostly legal gray advances, occasional jumps,
        // clears and resets.
        cur_bin = to_bin(gray_in);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 999);
            if (r < 550) begin
                // hold
            end else if (r < 850) begin
                cur_bin = cur_bin + W'($urandom_range(1, 3));
            end else if (r < 950) begin
                cur_bin = W'($urandom_range(0, 15));
            end
            gray_in = to_gray(cur_bin);
            err_clr = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 999) < 5) begin
                do_reset($urandom_range(1, 3));
            end
            tick();
        end
        err_clr = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_sync_decoder.md
# gray_sync_decoder

Destination-domain consumer for the gray-coded count produced by the team's gray counter. Brings the asynchronous gray bus into `clk` through a multi-stage synchronizer, converts it to binary, and reports per-cycle advance (`step`, `delta`). An optional checker flags any sampled transition that changes more than one bit; such a transition breaks the gray-code CDC guarantee.

## Interface
Parameters:
- `WIDTH`, 4: bus width in bits; ≥1.
- `STAGES`, 2: synchronizer depth in flops; ≥2.

Ports:
- `clk`  in  1  destination clock.
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `gray_in`  in  WIDTH  gray count from the source domain; asynchronous to `clk`.
- `err_clr`  in  1  synchronous clear of sticky `err`.
- `gray_out`  out  WIDTH  synchronized gray value, registered.
- `bin_out`  out  WIDTH  binary equivalent of `gray_out`, registered.
- `step`  out  1  one-cycle pulse when `bin_out` changes.
- `delta`  out  WIDTH  `(bin_out_new - bin_out_old) mod 2^WIDTH`, registered with `bin_out`.
- `err`  out  1  sticky multi-bit-change flag. Tied 0 when the checker is compiled out.

## Operation
- Synchronizer: chain `sync[0..STAGES-1]`. `sync[0] <= gray_in`; `sync[k] <= sync[k-1]`. No logic between stages.
- Output register: `gray_out <= sync[STAGES-1]`, and in the same cycle `bin_out <= g2b(sync[STAGES-1])`.
  - `g2b`: `b[WIDTH-1] = g[WIDTH-1]`; `b[i] = b[i+1] ^ g[i]`.
- Change detect: `step <= (sync[STAGES-1] != gray_out)`.
- `delta <= g2b(sync[STAGES-1]) - bin_out`, truncated to WIDTH bits. Wrap is modular, so 15→0 with WIDTH=4 gives `delta=1`. `delta` is 0 on cycles where `step=0`.
- Checker (macro on): `hd = popcount(sync[STAGES-1] ^ gray_out)`.
  - If `hd > 1`, set `err` on the next edge.
  - `err` holds until `err_clr` or `reset`.
  - If `err_clr` and a new violation occur in the same cycle, set wins, so `err` stays 1.
- The upstream counter must wrap at a power of two (`2^WIDTH`). A non-power-of-two wrap produces a multi-bit change at wrap and must raise `err`.
- Reset: all sync flops, `gray_out`, `bin_out`, `delta`, `step`, and `err` go to 0 immediately (asynchronous).
  - After reset release, the first compare is against `gray_out=0`.
  - If `gray_in` is non-zero at release, the first propagated value produces `step=1`. Its `delta` equals that binary value. `err` sets if that first value differs from 0 in >1 bit; this is accepted behaviour.
- Reset mid-operation discards all in-flight synchronizer contents. No partial outputs appear.

## Timing
- Latency: `gray_in` stable before edge N appears on `gray_out`/`bin_out` after edge N+STAGES. That is STAGES+1 edges, 3 at default.
- `step`, `delta`, and `err` update on the same edge as `bin_out`, so they are coincident with it.
- Throughput: one new value per `clk` cycle.
  - Source advance slower than `clk`: `delta=1` per `step`.
  - Faster source: `delta>1` is legal when bits change one at a time in gray order.
  - The checker judges only successive sampled values, so a fast source can also raise `err`.
- `err_clr` takes effect on the next edge. `err` reads 0 the cycle after, unless set again.

## Configuration
- `GRAY_SYNC_CHECK_EN` defined: Hamming-distance checker and sticky `err` register are built. `err_clr` is functional.
- Undefined: no checker logic. `err` is constant 0 and `err_clr` is ignored. All other behaviour is identical.

## Test plan
- Reset: assert `reset` with `gray_in=4'b0110`, then release. Expected: all outputs 0 during reset. `bin_out=4`, `step=1`, `delta=4` appear on the 3rd edge after release.
- Latency: from steady 0, drive `gray_in=0001` before edge N. Expected: `bin_out=1`, `step=1`, `delta=1` exactly after edge N+2 (STAGES=2), with `step=0` on the next cycle.
- Wrap: sweep gray 0..15 then 0 at one value per 4 clk. Expected: `bin_out` follows 0..15,0; every step gives `delta=1`, including 15→0 (`1000`→`0000`); `err=0` throughout.
- Violation (macro on): jump `gray_in` `0000`→`0111`. Expected: `err=1` coincident with `bin_out=5`. `err` stays 1 through later clean counts. `err_clr` for one cycle → `err=0`.
- Simultaneous: `err_clr=1` on the same edge as a new 2-bit jump. Expected: `err` remains 1. Same stimulus with the macro off: `err=0` always, `bin_out` is still correct.
- Mid-run reset: while counting at gray `0101`, pulse `reset` for 1 cycle asynchronously, holding `gray_in=0101`. Expected: outputs 0 immediately, then `bin_out=6`, `step=1`, `delta=6` three edges after release.
